// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage: registered, buffered RV32I instruction-decode stage.
//
// Fetch hands in {pc, instruction} pairs. They queue in a DEPTH-entry FIFO.
// The FIFO head is decoded combinationally. The result is captured in an
// output register that feeds the execute stage. Decoding covers the RV32I
// base set plus FENCE, which decodes as a NOP.
//
// Optional feature macro: DECODE_RV32M_EN
//   When defined, ALUREG instructions with funct7 = 0x01 decode as RV32M
//   multiply/divide operations.
//   When undefined, those instructions are illegal.
//
// Ports:
//   clk            in   core clock; all state updates on the rising edge
//   reset_n        in   synchronous active-low reset
//   flush          in   discard everything buffered and registered
//   in_valid       in   fetch presents an instruction
//   in_ready       out  stage can accept an instruction
//   in_pc          in   PC of the incoming instruction
//   in_instruction in   raw 32-bit instruction word
//   out_valid      out  decoded bundle valid
//   out_ready      in   execute consumes the bundle
//   out_pc         out  PC of the decoded instruction
//   out_rs1/rs2    out  source register fields
//   out_immediate  out  format-dependent immediate (0 for formats without one)
//   out_illegal_op out  instruction undecodable (out_control is then 0)
//   out_control    out  decoded control bundle (control_t)
//   occupancy      out  FIFO entries held, excluding the output register
//
// Handshake: a transfer occurs on a rising edge where valid && ready are both
// high. A producer holds valid and its data stable until the transfer. ready
// may depend combinationally on local state and flush. ready never depends
// on the same interface's valid.
// ---------------------------------------------------------------------------

package decode_pkg;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_EQ,
        ALU_NE,
        ALU_LT,
        ALU_GE,
        ALU_LTU,
        ALU_GEU
`ifdef DECODE_RV32M_EN
        ,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
`endif
    } alu_op_t;

    typedef enum logic [1:0] {
        SEL1_REG1 = 2'd0,
        SEL1_PC   = 2'd1,
        SEL1_ZERO = 2'd2
    } alu_select1_t;

    typedef enum logic {
        SEL2_REG2      = 1'b0,
        SEL2_IMMEDIATE = 1'b1
    } alu_select2_t;

    typedef enum logic [1:0] {
        BR_NEVER       = 2'd0,
        BR_CONDITIONAL = 2'd1,
        BR_ALWAYS      = 2'd2
    } branch_mode_t;

    // Selects the value written back to rd:
    //   - ALU result
    //   - load data
    //   - pc + 4 (the link value for JAL/JALR)
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_select_t;

    typedef struct packed {
        logic [4:0]   rd;
        logic         write_reg;
        alu_op_t      alu_op;
        alu_select1_t alu_select1;
        alu_select2_t alu_select2;
        branch_mode_t branch_mode;
        wb_select_t   wb_select;
        logic         mem_read;
        logic         mem_write;
        logic [2:0]   mem_funct3;  // access size / sign, straight from funct3
    } control_t;

endpackage

module decode_stage
    import decode_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_WIDTH-1:0]      in_pc,
    input  logic [31:0]              in_instruction,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [31:0]              out_immediate,
    output logic                     out_illegal_op,
    output control_t                 out_control,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUIMM = 7'b0010011;
    localparam logic [6:0] OP_ALUREG = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
    logic [31:0]         instr_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;

    logic push;
    logic load;

    // in_ready is low during reset and flush, so push implies neither.
    assign in_ready  = reset_n && !flush && (count != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign load      = (count != '0) && (!out_valid || out_ready);
    assign occupancy = count;

    // Storage array carries no reset. Entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instruction;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the FIFO head
    // ------------------------------------------------------------------
    logic [31:0] head_ins;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign head_ins = instr_mem[rd_ptr];
    assign opcode   = head_ins[6:0];
    assign funct3   = head_ins[14:12];
    assign funct7   = head_ins[31:25];

    assign imm_i = {{20{head_ins[31]}}, head_ins[31:20]};
    assign imm_s = {{20{head_ins[31]}}, head_ins[31:25], head_ins[11:7]};
    assign imm_b = {{19{head_ins[31]}}, head_ins[31], head_ins[7],
                    head_ins[30:25], head_ins[11:8], 1'b0};
    assign imm_u = {head_ins[31:12], 12'h000};
    assign imm_j = {{11{head_ins[31]}}, head_ins[31], head_ins[19:12],
                    head_ins[20], head_ins[30:21], 1'b0};

    control_t    dec_ctl;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    always_comb begin
        dec_ctl     = '0;
        dec_ctl.rd  = head_ins[11:7];
        dec_imm     = '0;
        dec_illegal = 1'b0;

        case (opcode)
            OP_LUI: begin
                dec_imm             = imm_u;
                dec_ctl.write_reg   = 1'b1;
                dec_ctl.alu_op      = ALU_ADD;
                dec_ctl.alu_select1 = SEL1_ZERO;
                dec_ctl.alu_select2 = SEL2_IMMEDIATE;
            end
            OP_AUIPC: begin
                dec_imm             = imm_u;
                dec_ctl.write_reg   = 1'b1;
                dec_ctl.alu_op      = ALU_ADD;
                dec_ctl.alu_select1 = SEL1_PC;
                dec_ctl.alu_select2 = SEL2_IMMEDIATE;
            end
            OP_JAL: begin
                // ALU forms the target. rd receives pc + 4.
                dec_imm             = imm_j;
                dec_ctl.write_reg   = 1'b1;
                dec_ctl.alu_op      = ALU_ADD;
                dec_ctl.alu_select1 = SEL1_PC;
                dec_ctl.alu_select2 = SEL2_IMMEDIATE;
                dec_ctl.branch_mode = BR_ALWAYS;
                dec_ctl.wb_select   = WB_PC4;
            end
            OP_JALR: begin
                dec_imm             = imm_i;
                dec_ctl.write_reg   = 1'b1;
                dec_ctl.alu_op      = ALU_ADD;
                dec_ctl.alu_select1 = SEL1_REG1;
                dec_ctl.alu_select2 = SEL2_IMMEDIATE;
                dec_ctl.branch_mode = BR_ALWAYS;
                dec_ctl.wb_select   = WB_PC4;
            end
            OP_BRANCH: begin
                // ALU evaluates the condition. The target is pc + immediate.
                dec_imm             = imm_b;
                dec_ctl.alu_select1 = SEL1_REG1;
                dec_ctl.alu_select2 = SEL2_REG2;
                dec_ctl.branch_mode = BR_CONDITIONAL;
                case (funct3)
                    3'b000:  dec_ctl.alu_op = ALU_EQ;
                    3'b001:  dec_ctl.alu_op = ALU_NE;
                    3'b100:  dec_ctl.alu_op = ALU_LT;
                    3'b101:  dec_ctl.alu_op = ALU_GE;
                    3'b110:  dec_ctl.alu_op = ALU_LTU;
                    3'b111:  dec_ctl.alu_op = ALU_GEU;
                    default: dec_illegal    = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec_imm             = imm_i;
                dec_ctl.write_reg   = 1'b1;
                dec_ctl.alu_op      = ALU_ADD;
                dec_ctl.alu_select1 = SEL1_REG1;
                dec_ctl.alu_select2 = SEL2_IMMEDIATE;
                dec_ctl.wb_select   = WB_MEM;
                dec_ctl.mem_read    = 1'b1;
                dec_ctl.mem_funct3  = funct3;
            end
            OP_STORE: begin
                dec_imm             = imm_s;
                dec_ctl.alu_op      = ALU_ADD;
                dec_ctl.alu_select1 = SEL1_REG1;
                dec_ctl.alu_select2 = SEL2_IMMEDIATE;
                dec_ctl.mem_write   = 1'b1;
                dec_ctl.mem_funct3  = funct3;
            end
            OP_ALUIMM: begin
                dec_imm             = imm_i;
                dec_ctl.write_reg   = 1'b1;
                dec_ctl.alu_select1 = SEL1_REG1;
                dec_ctl.alu_select2 = SEL2_IMMEDIATE;
                case (funct3)
                    3'b000: dec_ctl.alu_op = ALU_ADD;
                    3'b001: dec_ctl.alu_op = ALU_SLL;
                    3'b010: dec_ctl.alu_op = ALU_SLT;
                    3'b011: dec_ctl.alu_op = ALU_SLTU;
                    3'b100: dec_ctl.alu_op = ALU_XOR;
                    3'b101: dec_ctl.alu_op = head_ins[30] ? ALU_SRA : ALU_SRL;
                    3'b110: dec_ctl.alu_op = ALU_OR;
                    3'b111: dec_ctl.alu_op = ALU_AND;
                endcase
            end
            OP_ALUREG: begin
                dec_ctl.write_reg   = 1'b1;
                dec_ctl.alu_select1 = SEL1_REG1;
                dec_ctl.alu_select2 = SEL2_REG2;
                case (funct7)
                    7'h00: begin
                        case (funct3)
                            3'b000: dec_ctl.alu_op = ALU_ADD;
                            3'b001: dec_ctl.alu_op = ALU_SLL;
                            3'b010: dec_ctl.alu_op = ALU_SLT;
                            3'b011: dec_ctl.alu_op = ALU_SLTU;
                            3'b100: dec_ctl.alu_op = ALU_XOR;
                            3'b101: dec_ctl.alu_op = ALU_SRL;
                            3'b110: dec_ctl.alu_op = ALU_OR;
                            3'b111: dec_ctl.alu_op = ALU_AND;
                        endcase
                    end
                    7'h20: begin
                        case (funct3)
                            3'b000:  dec_ctl.alu_op = ALU_SUB;
                            3'b101:  dec_ctl.alu_op = ALU_SRA;
                            default: dec_illegal    = 1'b1;
                        endcase
                    end
`ifdef DECODE_RV32M_EN
                    7'h01: begin
                        case (funct3)
                            3'b000: dec_ctl.alu_op = ALU_MUL;
                            3'b001: dec_ctl.alu_op = ALU_MULH;
                            3'b010: dec_ctl.alu_op = ALU_MULHSU;
                            3'b011: dec_ctl.alu_op = ALU_MULHU;
                            3'b100: dec_ctl.alu_op = ALU_DIV;
                            3'b101: dec_ctl.alu_op = ALU_DIVU;
                            3'b110: dec_ctl.alu_op = ALU_REM;
                            3'b111: dec_ctl.alu_op = ALU_REMU;
                        endcase
                    end
`endif
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_FENCE: begin
                // Single-hart, in-order memory system: ordering is implicit,
                // so FENCE retires as a no-op with a zero immediate.
                dec_ctl.alu_op      = ALU_ADD;
                dec_ctl.alu_select1 = SEL1_REG1;
                dec_ctl.alu_select2 = SEL2_IMMEDIATE;
            end
            default: dec_illegal = 1'b1;
        endcase

        if (dec_illegal) begin
            dec_ctl = '0;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and the output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            out_valid      <= 1'b0;
            out_pc         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_immediate  <= '0;
            out_illegal_op <= 1'b0;
            out_control    <= '0;
        end else if (flush) begin
            // Bundle data is left as is. out_valid = 0 marks it dead.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr         <= rd_ptr + 1'b1;
                out_valid      <= 1'b1;
                out_pc         <= pc_mem[rd_ptr];
                out_rs1        <= head_ins[19:15];
                out_rs2        <= head_ins[24:20];
                out_immediate  <= dec_imm;
                out_illegal_op <= dec_illegal;
                out_control    <= dec_ctl;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case ({push, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, buffered instruction-decode stage for the RV32I core.
- Accepts {pc, instruction} pairs from fetch over a valid/ready handshake and holds them in a DEPTH-entry FIFO.
- Decodes the FIFO head into rs1/rs2/immediate/control_t.
- Presents the decoded bundle in an output register to the execute stage, also over valid/ready.
- Supports pipeline flush. Adds FENCE decoding and optional RV32M decoding.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of 2, >= 2.
- PC_WIDTH, 32, width of the carried program counter.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset.
- flush  input  1  discard all buffered and registered instructions.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept an instruction.
- in_pc  input  PC_WIDTH  PC of incoming instruction.
- in_instruction  input  32  raw instruction word.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute consumes bundle.
- out_pc  output  PC_WIDTH  PC of decoded instruction.
- out_rs1  output  5  source register 1, instruction[19:15].
- out_rs2  output  5  source register 2, instruction[24:20].
- out_immediate  output  32  sign/zero-extended immediate, per I/S/B/U/J format; 0 for other opcodes.
- out_illegal_op  output  1  instruction undecodable.
- out_control  output  control_t  decoded control bundle; rd = instruction[11:7].
- occupancy  output  $clog2(DEPTH)+1  FIFO entries held; excludes the output register.

Behaviour:
- Reset (reset_n=0 at edge): FIFO pointers and occupancy -> 0, out_valid=0. Bundle outputs (pc, rs1, rs2, immediate, illegal_op, control) -> 0. in_ready=0 while reset_n=0.
- in_ready = !flush && (occupancy != DEPTH), combinational. Input accept = in_valid && in_ready; the entry is written at the edge.
- No combinational pass-through from input to output.
- Output load condition: FIFO non-empty && (!out_valid || out_ready). When true, the head is decoded and registered at the edge, the FIFO pops, and out_valid=1. Otherwise, if out_ready && out_valid, out_valid -> 0. A held bundle is stable while out_valid && !out_ready.
- Latency: an instruction accepted at edge t into an empty stage gives out_valid=1 after edge t+1. Sustained throughput is 1 instruction/cycle.
- Simultaneous push and pop: occupancy unchanged; legal when full only if pop happens, but in_ready already reads 0 when full (no full-bypass).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is separate, 0..DEPTH.
- flush (priority below reset): at the edge, FIFO emptied, occupancy=0, out_valid=0; no push or pop that cycle. Bundle data registers may keep stale values.
- Decode rules:
  - LUI/AUIPC/JAL/JALR/BRANCH/LOAD/STORE/ALUIMM/ALUREG: identical control encoding to the existing RV32I decode.
  - Branch funct3 010/011 -> illegal.
  - ALUREG funct7 other than 0x00/0x20 -> illegal (unless the optional feature applies).
  - FENCE (opcode 0001111): legal NOP. write_reg=0, alu_op=ADD, alu_select1=REG1, alu_select2=IMMEDIATE, branch_mode=NEVER, no memory access, immediate=0.
  - Any other opcode, including SYSTEM 1110011: illegal.
- Illegal: out_illegal_op=1 and out_control=0. out_rs1/out_rs2/out_pc/out_immediate are still the computed field values. Illegal instructions flow through the handshake like any other.

Optional Feature:
- Macro: DECODE_RV32M_EN.
- Defined:
  - ALUREG with funct7=0x01 is legal, otherwise encoded as ALUREG (write_reg=1, alu_select2=REG2).
  - alu_op selected from funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - alu_op_t gains these enumerators under the same macro.
- Undefined: funct7=0x01 -> illegal, control=0.

Test Plan:
- Reset with reset_n=0 for 2 cycles, in_valid=1 -> in_ready=0, out_valid=0, occupancy=0, all bundle outputs 0.
- ADDI 0x00500093 at pc 0x100, out_ready=1 -> after 2 edges out_valid=1, out_pc=0x100, rd=1, rs1=0, immediate=5, alu_op=ADD, alu_select2=IMMEDIATE, illegal=0.
- DEPTH=4, out_ready=0, in_valid held with 6 distinct words -> 5 accepted, in_ready=0 with occupancy=4. Raising out_ready drains all 5 in order on 5 consecutive cycles.
- Back-pressure toggle:
  - Stream SUB 0x402081B3 then BEQ 0x00208463 with out_ready pattern 1,0,1 -> no loss or duplication.
  - SUB gives alu_op=SUB, rd=3.
  - BEQ gives immediate=8 and alu_op=EQ; it is held stable during the stall.
- Full FIFO + registered output, pulse flush for one cycle -> next cycle out_valid=0, occupancy=0, in_ready=1. An instruction pushed afterward appears with correct pc.
- 0x00002063 (branch funct3 010) -> illegal=1, control=0. FENCE 0x0FF0000F -> illegal=0, write_reg=0. MUL 0x027302B3 -> alu_op=MUL when DECODE_RV32M_EN is defined, illegal=1 otherwise.
